// File: rtl/cpu_state_dump.sv
// Architectural state readout: stalls the core, then streams r0..rN and m0..mM
// as tagged records through a single-entry valid/ready output register.
module cpu_state_dump #(
    parameter int NUM_REGS = 32,
    parameter int NUM_MEM  = 32,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 5
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [4:0]        rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [31:0]       dm_addr_o,
    input  logic [DATA_W-1:0] dm_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_is_mem_o,
    output logic [IDX_W-1:0]  out_index_o
);

    typedef enum logic [2:0] {
        IDLE,
        REG,
        MEM,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic              load;
    logic              hs;
    logic              last_reg;
    logic              last_mem;

    assign hs       = out_valid_o & out_ready_i;
    assign last_reg = (idx_q == IDX_W'(NUM_REGS - 1));
    assign last_mem = (idx_q == IDX_W'(NUM_MEM - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = REG;
                    idx_d   = '0;
                end
            end
            REG: begin
                if (load) begin
                    if (last_reg) begin
                        state_d = MEM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            MEM: begin
                if (load) begin
                    if (last_mem) begin
                        state_d = DRAIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (hs) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_o    = (state_q != IDLE);
        stall_o   = busy_o;
        done_o    = (state_q == DONE);
        rf_addr_o = '0;
        dm_addr_o = '0;
        load      = 1'b0;
        if (state_q == REG) begin
            rf_addr_o = 5'(idx_q);
            load      = !out_valid_o || out_ready_i;
        end
        if (state_q == MEM) begin
            dm_addr_o = 32'({idx_q, 2'b00});
            load      = !out_valid_o || out_ready_i;
        end
    end

    // Output slot reloads on the same edge it hands off, so ready=1 gives no bubbles.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            out_valid_o  <= 1'b0;
            out_data_o   <= '0;
            out_is_mem_o <= 1'b0;
            out_index_o  <= '0;
        end else if (load) begin
            out_valid_o  <= 1'b1;
            out_data_o   <= (state_q == MEM) ? dm_data_i : rf_data_i;
            out_is_mem_o <= (state_q == MEM);
            out_index_o  <= idx_q;
        end else if (state_q == DRAIN && hs) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_state_dump.sv
// Bench for cpu_state_dump: queue-based record model plus directed scenarios.
module tb_cpu_state_dump;

    typedef logic [37:0] rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    logic        busy, stall, done, valid, is_mem;
    logic [4:0]  rf_addr, index;
    logic [31:0] dm_addr, rf_data, dm_data, data;

    logic        start1 = 1'b0;
    logic        ready1 = 1'b1;
    logic        busy1, stall1, done1, valid1, is_mem1;
    logic [4:0]  rf_addr1, index1;
    logic [31:0] dm_addr1, rf_data1, dm_data1, data1;

    logic [31:0] rf_mem [32];
    logic [31:0] dm_mem [32];

    int   total = 0;
    int   bad = 0;
    int   mode = 0;
    int   hc = 0;
    bit   en = 0;
    bit   m_idle = 1;
    bit   m_done = 0;
    bit   prev_hold = 0;
    rec_t prev_rec;
    rec_t q[$];
    rec_t acc[$];

    always #5 clk = ~clk;

    cpu_state_dump u0 (
        .clk_i(clk), .rst_n(rst_n), .start_i(start),
        .busy_o(busy), .stall_o(stall), .done_o(done),
        .rf_addr_o(rf_addr), .rf_data_i(rf_data),
        .dm_addr_o(dm_addr), .dm_data_i(dm_data),
        .out_valid_o(valid), .out_ready_i(ready),
        .out_data_o(data), .out_is_mem_o(is_mem),
        .out_index_o(index)
    );

    cpu_state_dump #(.NUM_REGS(1), .NUM_MEM(1)) u1 (
        .clk_i(clk), .rst_n(rst_n), .start_i(start1),
        .busy_o(busy1), .stall_o(stall1), .done_o(done1),
        .rf_addr_o(rf_addr1), .rf_data_i(rf_data1),
        .dm_addr_o(dm_addr1), .dm_data_i(dm_data1),
        .out_valid_o(valid1), .out_ready_i(ready1),
        .out_data_o(data1), .out_is_mem_o(is_mem1),
        .out_index_o(index1)
    );

    always_comb begin
        rf_data = rf_mem[rf_addr];
        dm_data = 32'hDEAD_BEEF;
        if (dm_addr[1:0] == 2'b00 && dm_addr < 32'd128)
            dm_data = dm_mem[dm_addr[6:2]];
        rf_data1 = (rf_addr1 == 5'd0) ? 32'hA5A5_0001 : 32'hDEAD_BEEF;
        dm_data1 = (dm_addr1 == 32'd0) ? 32'h5A5A_0002 : 32'hDEAD_BEEF;
    end

    function automatic rec_t mk(input logic m, input int i, input logic [31:0] d);
        return {m, i[4:0], d};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_dump();
        for (int i = 0; i < 32; i++) q.push_back(mk(1'b0, i, 32'(i + 100)));
        for (int i = 0; i < 32; i++) q.push_back(mk(1'b1, i, 32'(i * 3)));
    endtask

    task automatic wait_done(input string nm, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < bound);
        chk({nm, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        case (mode)
            1: ready = ~ready;
            2: begin
                if (valid && !is_mem && index == 5'd31 && hc < 3) begin
                    ready = 1'b0;
                    hc++;
                end else begin
                    ready = 1'b1;
                end
            end
            3: ready = !(valid && is_mem && index == 5'd5);
            default: ready = 1'b1;
        endcase
    end

    // Model: a dump is 64 fixed records; done follows the last hand-off.
    always @(negedge clk) begin
        rec_t cur;
        bit   was_idle;
        bit   nd;
        if (en) begin
            cur = {is_mem, index, data};
            nd = 0;
            chk("busy", 64'(busy), 64'(!m_idle));
            chk("stall", 64'(stall), 64'(busy));
            chk("done", 64'(done), 64'(m_done));
            if (m_idle) begin
                chk("idle_valid", 64'(valid), 64'd0);
                chk("idle_addr", {27'd0, rf_addr, dm_addr}, 64'd0);
            end
            if (prev_hold) chk("hold", {valid, cur}, {1'b1, prev_rec});
            if (valid && ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_rec: got %0h expected none", cur);
                end else begin
                    chk("rec", 64'(cur), 64'(q.pop_front()));
                    if (q.size() == 0) nd = 1;
                end
                acc.push_back(cur);
            end
            if (!rst_n) begin
                q.delete();
                m_idle = 1;
                m_done = 0;
                prev_hold = 0;
            end else begin
                was_idle = m_idle;
                if (m_done) m_idle = 1;
                if (was_idle && start) begin
                    m_idle = 0;
                    push_dump();
                end
                m_done = nd;
                prev_hold = valid && !ready;
                prev_rec = cur;
            end
        end
    end

    initial begin
        int n;
        int dn;
        rec_t r1[$];
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 32'(i + 100);
            dm_mem[i] = 32'(i * 3);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_u0", {busy, stall, done, valid, is_mem, index, data}, 64'd0);
        chk("reset_addr", {27'd0, rf_addr, dm_addr}, 64'd0);
        chk("reset_u1", {busy1, valid1, done1, data1}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        en = 1;

        // full dump, ready always high: exact cycle timing
        mode = 0;
        acc.delete();
        pulse_start();
        for (int k = 0; k <= 66; k++) begin
            @(negedge clk);
            chk($sformatf("t1_valid_%0d", k), 64'(valid), 64'(k >= 1 && k <= 64));
            chk($sformatf("t1_done_%0d", k), 64'(done), 64'(k == 65));
            chk($sformatf("t1_busy_%0d", k), 64'(busy), 64'(k <= 65));
        end
        chk("t1_count", 64'(acc.size()), 64'd64);
        chk("t1_r0", 64'(acc[0]), 64'(mk(1'b0, 0, 32'd100)));
        chk("t1_r31", 64'(acc[31]), 64'(mk(1'b0, 31, 32'd131)));
        chk("t1_m0", 64'(acc[32]), 64'(mk(1'b1, 0, 32'd0)));
        chk("t1_m31", 64'(acc[63]), 64'(mk(1'b1, 31, 32'd93)));

        // toggling ready
        repeat (3) @(posedge clk);
        mode = 1;
        acc.delete();
        pulse_start();
        wait_done("t2", 400);
        chk("t2_count", 64'(acc.size()), 64'd64);
        chk("t2_m1", 64'(acc[33]), 64'(mk(1'b1, 1, 32'd3)));

        // back-pressure on r31 across the REG->MEM boundary
        repeat (3) @(posedge clk);
        mode = 2;
        hc = 0;
        acc.delete();
        pulse_start();
        wait_done("t3", 400);
        chk("t3_hold_cycles", 64'(hc), 64'd3);
        chk("t3_r31", 64'(acc[31]), 64'(mk(1'b0, 31, 32'd131)));
        chk("t3_m0", 64'(acc[32]), 64'(mk(1'b1, 0, 32'd0)));

        // start held high: two back-to-back dumps, separated by IDLE
        repeat (3) @(posedge clk);
        mode = 0;
        acc.delete();
        @(posedge clk);
        #1 start = 1'b1;
        wait_done("t4a", 200);
        chk("t4_first", 64'(acc.size()), 64'd64);
        wait_done("t4b", 200);
        start = 1'b0;
        chk("t4_second", 64'(acc.size()), 64'd128);
        chk("t4_r0b", 64'(acc[64]), 64'(mk(1'b0, 0, 32'd100)));

        // reset while m5 is held
        repeat (4) @(posedge clk);
        mode = 3;
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(valid && is_mem && index == 5'd5 && !ready) && n < 200);
        chk("t5_m5_held", {valid, is_mem, index, ready}, {1'b1, 1'b1, 5'd5, 1'b0});
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        mode = 0;
        @(negedge clk);
        chk("t5_after_rst", {busy, stall, done, valid, index}, 64'd0);
        chk("t5_addr", {27'd0, rf_addr, dm_addr}, 64'd0);
        acc.delete();
        pulse_start();
        wait_done("t5", 200);
        chk("t5_r0", 64'(acc[0]), 64'(mk(1'b0, 0, 32'd100)));
        chk("t5_count", 64'(acc.size()), 64'd64);

        // minimal configuration instance
        repeat (3) @(posedge clk);
        dn = 0;
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid1 && ready1) r1.push_back({is_mem1, index1, data1});
            if (done1) dn++;
        end
        chk("t6_count", 64'(r1.size()), 64'd2);
        chk("t6_rec0", 64'(r1[0]), 64'(mk(1'b0, 0, 32'hA5A5_0001)));
        chk("t6_rec1", 64'(r1[1]), 64'(mk(1'b1, 0, 32'h5A5A_0002)));
        chk("t6_dones", 64'(dn), 64'd1);
        chk("t6_idle", {busy1, stall1, valid1}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
